// File: rtl/dmem_access_unit_pkg.sv
// Shared constants for the MEM-stage data-memory access path:
// load/store funct3 encodings, the access FSM state type and
// small decode helpers used by the access unit and its load aligner.
package dmem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Byte-sized op (LB, LBU, SB): low two funct3 bits are 00.
   function automatic logic is_byte_op(input logic [2:0] f3);
      return (f3[1:0] == F3_B[1:0]);
   endfunction

   // Half-sized op (LH, LHU, SH): low two funct3 bits are 01.
   function automatic logic is_half_op(input logic [2:0] f3);
      return (f3[1:0] == F3_H[1:0]);
   endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the
// data memory (slave): request strobes, word address, lane data,
// byte enables and the one-cycle completion acknowledge.
interface dmem_access_unit_if #(parameter int ADDR_WIDTH = 32);

   logic                  dmem_read;
   logic                  dmem_write;
   logic [ADDR_WIDTH-3:0] dmem_address;
   logic [31:0]           dmem_writedata;
   logic [3:0]            dmem_byte_en;
   logic [31:0]           dmem_readdata;
   logic                  dmem_ack;

   modport master (
      output dmem_read, dmem_write, dmem_address, dmem_writedata, dmem_byte_en,
      input  dmem_readdata, dmem_ack
   );

   modport slave (
      input  dmem_read, dmem_write, dmem_address, dmem_writedata, dmem_byte_en,
      output dmem_readdata, dmem_ack
   );

endinterface

// File: rtl/dmem_access_unit_load_align_unit.sv
// Picks the addressed byte or halfword out of a memory word and
// sign- or zero-extends it according to the load funct3. Anything that
// is not a byte or half load is returned as the full word.
module load_align_unit
   import dmem_access_unit_pkg::*;
(
   input  logic [31:0] load_word,
   input  logic [1:0]  offset,
   input  logic [2:0]  func3,
   output logic [31:0] load_value
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Lane selection by byte offset, then extension by load type.
   always_comb begin
      lane_byte  = load_word[7:0];
      lane_half  = load_word[15:0];
      load_value = load_word;
      case (offset)
         2'd0: lane_byte = load_word[7:0];
         2'd1: lane_byte = load_word[15:8];
         2'd2: lane_byte = load_word[23:16];
         2'd3: lane_byte = load_word[31:24];
         default: lane_byte = load_word[7:0];
      endcase
      if (offset[1]) begin
         lane_half = load_word[31:16];
      end
      case (func3)
         F3_B:    load_value = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   load_value = {24'd0, lane_byte};
         F3_H:    load_value = {{16{lane_half[15]}}, lane_half};
         F3_HU:   load_value = {16'd0, lane_half};
         default: load_value = load_word;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller. Chooses forwarded or
// register store data, formats byte/half/word stores onto byte lanes,
// runs the request/ack handshake with data memory while stalling the
// pipeline, and registers the extended load result for MEM/WB.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read_en,
   input  logic                  mem_write_en,
   input  logic [2:0]            func3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] reg_data2,
   input  logic [DATA_WIDTH-1:0] fwd_data_wb,
   input  logic                  mem_fwd_sel,
   dmem_access_unit_if.master    dmem,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  busywait,
   output logic                  misaligned
);

   state_t state, state_next;

   logic                  req;
   logic                  byte_op;
   logic                  half_op;
   logic                  word_op;
   logic                  addr_misaligned;
   logic                  issue;
   logic [DATA_WIDTH-1:0] store_data;
   logic [31:0]           wdata_fmt;
   logic [3:0]            be_fmt;

   logic [ADDR_WIDTH-3:0] addr_q;
   logic [1:0]            offset_q;
   logic [2:0]            func3_q;
   logic [31:0]           wdata_q;
   logic [3:0]            be_q;
   logic                  is_write_q;
   logic [31:0]           load_value;

   // Decode the presented instruction: alignment check, store-data
   // selection and lane formatting. A load gets all four byte enables.
   always_comb begin
      req             = mem_read_en | mem_write_en;
      byte_op         = is_byte_op(func3);
      half_op         = is_half_op(func3);
      word_op         = !byte_op && !half_op;
      addr_misaligned = (word_op && (address[1:0] != 2'b00)) || (half_op && address[0]);
      misaligned      = (state == IDLE) && req && addr_misaligned;
      issue           = (state == IDLE) && req && !addr_misaligned;
      store_data      = mem_fwd_sel ? fwd_data_wb : reg_data2;
      wdata_fmt       = store_data;
      be_fmt          = 4'b1111;
      if (mem_write_en) begin
         if (byte_op) begin
            wdata_fmt = {4{store_data[7:0]}};
            be_fmt    = 4'b0001 << address[1:0];
         end else if (half_op) begin
            wdata_fmt = {2{store_data[15:0]}};
            be_fmt    = address[1] ? 4'b1100 : 4'b0011;
         end
      end
   end

   // Next state and handshake strobes. DONE drops the stall without
   // re-issuing, since the same instruction is still on the inputs.
   always_comb begin
      state_next      = state;
      dmem.dmem_read  = 1'b0;
      dmem.dmem_write = 1'b0;
      busywait        = 1'b0;
      case (state)
         IDLE: begin
            busywait = issue;
            if (issue) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            dmem.dmem_read  = !is_write_q;
            dmem.dmem_write = is_write_q;
            busywait        = 1'b1;
            if (dmem.dmem_ack) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register, request latches captured at issue, and the load
   // result captured only on an acknowledged read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         offset_q   <= 2'd0;
         func3_q    <= 3'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         is_write_q <= 1'b0;
         read_data  <= '0;
      end else begin
         state <= state_next;
         if (issue) begin
            addr_q     <= address[ADDR_WIDTH-1:2];
            offset_q   <= address[1:0];
            func3_q    <= func3;
            wdata_q    <= wdata_fmt;
            be_q       <= be_fmt;
            is_write_q <= mem_write_en;
         end
         if ((state == ACCESS) && dmem.dmem_ack && !is_write_q) begin
            read_data <= load_value;
         end
      end
   end

   assign dmem.dmem_address   = addr_q;
   assign dmem.dmem_writedata = wdata_q;
   assign dmem.dmem_byte_en   = be_q;

   load_align_unit u_load_align (
      .load_word  (dmem.dmem_readdata),
      .offset     (offset_q),
      .func3      (func3_q),
      .load_value (load_value)
   );

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: the bench plays data memory,
// drives one instruction at a time and checks strobes, stall, lane
// formatting and load extension against hand-computed values.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [2:0]  func3;
   logic [31:0] address;
   logic [31:0] reg_data2;
   logic [31:0] fwd_data_wb;
   logic        mem_fwd_sel;
   logic [31:0] read_data;
   logic        busywait;
   logic        misaligned;

   int vectors     = 0;
   int miscompares = 0;
   int read_req_cycles = 0;

   dmem_access_unit_if #(.ADDR_WIDTH(32)) dmem_bus ();

   dmem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .func3        (func3),
      .address      (address),
      .reg_data2    (reg_data2),
      .fwd_data_wb  (fwd_data_wb),
      .mem_fwd_sel  (mem_fwd_sel),
      .dmem         (dmem_bus.master),
      .read_data    (read_data),
      .busywait     (busywait),
      .misaligned   (misaligned)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Count cycles with a read request in flight, sampled mid-cycle.
   always @(negedge clk) begin
      if (dmem_bus.dmem_read === 1'b1) read_req_cycles++;
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task clear_inputs;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      func3        = 3'b000;
      address      = 32'h0;
      reg_data2    = 32'h0;
      fwd_data_wb  = 32'h0;
      mem_fwd_sel  = 1'b0;
      dmem_bus.dmem_ack      = 1'b0;
      dmem_bus.dmem_readdata = 32'h0;
   endtask

   task test_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
      vectors++; if (dmem_bus.dmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_read: got %b expected 0", dmem_bus.dmem_read); end
      vectors++; if (dmem_bus.dmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_write: got %b expected 0", dmem_bus.dmem_write); end
      vectors++; if (busywait !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busywait: got %b expected 0", busywait); end
      vectors++; if (dmem_bus.dmem_address !== 30'h0) begin miscompares++; $display("[TB] FAIL reset_address: got %h expected 0", dmem_bus.dmem_address); end
      vectors++; if (dmem_bus.dmem_writedata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_writedata: got %h expected 0", dmem_bus.dmem_writedata); end
      vectors++; if (dmem_bus.dmem_byte_en !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_byte_en: got %b expected 0000", dmem_bus.dmem_byte_en); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_read_data: got %h expected 0", read_data); end
   endtask

   task test_store_word;
      mem_write_en = 1'b1;
      func3        = 3'b010;
      address      = 32'h0000_0010;
      reg_data2    = 32'hDEADBEEF;
      fwd_data_wb  = 32'h0BADF00D;
      mem_fwd_sel  = 1'b0;
      #1;
      vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_issue_busy: got %b expected 1", busywait); end
      vectors++; if (dmem_bus.dmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_issue_write: got %b expected 0", dmem_bus.dmem_write); end
      tick();
      vectors++; if (dmem_bus.dmem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_access1_write: got %b expected 1", dmem_bus.dmem_write); end
      vectors++; if (dmem_bus.dmem_address !== 30'h4) begin miscompares++; $display("[TB] FAIL sw_address: got %h expected 4", dmem_bus.dmem_address); end
      vectors++; if (dmem_bus.dmem_byte_en !== 4'b1111) begin miscompares++; $display("[TB] FAIL sw_byte_en: got %b expected 1111", dmem_bus.dmem_byte_en); end
      vectors++; if (dmem_bus.dmem_writedata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL sw_writedata: got %h expected deadbeef", dmem_bus.dmem_writedata); end
      vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_access1_busy: got %b expected 1", busywait); end
      tick();
      dmem_bus.dmem_ack = 1'b1;
      vectors++; if (dmem_bus.dmem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_access2_write: got %b expected 1", dmem_bus.dmem_write); end
      vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_access2_busy: got %b expected 1", busywait); end
      tick();
      dmem_bus.dmem_ack = 1'b0;
      vectors++; if (dmem_bus.dmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_done_write: got %b expected 0", dmem_bus.dmem_write); end
      vectors++; if (busywait !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_done_busy: got %b expected 0", busywait); end
      clear_inputs();
      tick();
      vectors++; if (dmem_bus.dmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_after_write: got %b expected 0", dmem_bus.dmem_write); end
   endtask

   task test_store_byte_fwd;
      mem_write_en = 1'b1;
      func3        = 3'b000;
      address      = 32'h0000_0013;
      reg_data2    = 32'h11111111;
      fwd_data_wb  = 32'h000000A5;
      mem_fwd_sel  = 1'b1;
      #1;
      vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_issue_busy: got %b expected 1", busywait); end
      tick();
      vectors++; if (dmem_bus.dmem_writedata !== 32'hA5A5A5A5) begin miscompares++; $display("[TB] FAIL sb_writedata: got %h expected a5a5a5a5", dmem_bus.dmem_writedata); end
      vectors++; if (dmem_bus.dmem_byte_en !== 4'b1000) begin miscompares++; $display("[TB] FAIL sb_byte_en: got %b expected 1000", dmem_bus.dmem_byte_en); end
      vectors++; if (dmem_bus.dmem_address !== 30'h4) begin miscompares++; $display("[TB] FAIL sb_address: got %h expected 4", dmem_bus.dmem_address); end
      dmem_bus.dmem_ack = 1'b1;
      tick();
      dmem_bus.dmem_ack = 1'b0;
      vectors++; if (busywait !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_done_busy: got %b expected 0", busywait); end
      clear_inputs();
      tick();
   endtask

   task test_loads;
      logic [2:0]  f3_tab  [3];
      logic [31:0] exp_tab [3];
      f3_tab[0] = 3'b000; exp_tab[0] = 32'hFFFFFFF0;
      f3_tab[1] = 3'b100; exp_tab[1] = 32'h000000F0;
      f3_tab[2] = 3'b101; exp_tab[2] = 32'h000012F0;
      for (int i = 0; i < 3; i++) begin
         mem_read_en = 1'b1;
         func3       = f3_tab[i];
         address     = 32'h0000_0022;
         #1;
         vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL load%0d_issue_busy: got %b expected 1", i, busywait); end
         tick();
         vectors++; if (dmem_bus.dmem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL load%0d_read: got %b expected 1", i, dmem_bus.dmem_read); end
         vectors++; if (dmem_bus.dmem_byte_en !== 4'b1111) begin miscompares++; $display("[TB] FAIL load%0d_byte_en: got %b expected 1111", i, dmem_bus.dmem_byte_en); end
         dmem_bus.dmem_readdata = 32'h12F03456;
         dmem_bus.dmem_ack      = 1'b1;
         tick();
         dmem_bus.dmem_ack      = 1'b0;
         dmem_bus.dmem_readdata = 32'h0;
         vectors++; if (read_data !== exp_tab[i]) begin miscompares++; $display("[TB] FAIL load%0d_read_data: got %h expected %h", i, read_data, exp_tab[i]); end
         vectors++; if (dmem_bus.dmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_done_read: got %b expected 0", i, dmem_bus.dmem_read); end
         clear_inputs();
         tick();
      end
   endtask

   task test_misaligned;
      logic        rd_tab [2];
      logic [2:0]  f3_tab [2];
      logic [31:0] ad_tab [2];
      rd_tab[0] = 1'b1; f3_tab[0] = 3'b010; ad_tab[0] = 32'h06;
      rd_tab[1] = 1'b0; f3_tab[1] = 3'b001; ad_tab[1] = 32'h01;
      for (int i = 0; i < 2; i++) begin
         mem_read_en  = rd_tab[i];
         mem_write_en = !rd_tab[i];
         func3        = f3_tab[i];
         address      = ad_tab[i];
         reg_data2    = 32'hCAFE_BABE;
         #1;
         vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("[TB] FAIL mis%0d_flag: got %b expected 1", i, misaligned); end
         vectors++; if (busywait !== 1'b0) begin miscompares++; $display("[TB] FAIL mis%0d_busy: got %b expected 0", i, busywait); end
         tick();
         vectors++; if ((dmem_bus.dmem_read | dmem_bus.dmem_write) !== 1'b0) begin miscompares++; $display("[TB] FAIL mis%0d_request: got %b expected 0", i, dmem_bus.dmem_read | dmem_bus.dmem_write); end
         vectors++; if (read_data !== 32'h000012F0) begin miscompares++; $display("[TB] FAIL mis%0d_read_data: got %h expected 000012f0", i, read_data); end
         clear_inputs();
         tick();
      end
   endtask

   task test_reset_in_access;
      mem_read_en = 1'b1;
      func3       = 3'b010;
      address     = 32'h0000_0008;
      tick();
      vectors++; if (dmem_bus.dmem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_access_read: got %b expected 1", dmem_bus.dmem_read); end
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
      vectors++; if (dmem_bus.dmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_strobe: got %b expected 0", dmem_bus.dmem_read); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_read_data: got %h expected 0", read_data); end
      dmem_bus.dmem_readdata = 32'hFFFFFFFF;
      dmem_bus.dmem_ack      = 1'b1;
      tick();
      dmem_bus.dmem_ack      = 1'b0;
      dmem_bus.dmem_readdata = 32'h0;
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("[TB] FAIL stray_ack_read_data: got %h expected 0", read_data); end
      vectors++; if (busywait !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_ack_busy: got %b expected 0", busywait); end
      tick();
   endtask

   task test_back_to_back;
      int start_count;
      start_count = read_req_cycles;
      mem_read_en = 1'b1;
      func3       = 3'b010;
      address     = 32'h0;
      tick();
      vectors++; if (dmem_bus.dmem_address !== 30'h0) begin miscompares++; $display("[TB] FAIL b2b0_address: got %h expected 0", dmem_bus.dmem_address); end
      dmem_bus.dmem_readdata = 32'h11223344;
      dmem_bus.dmem_ack      = 1'b1;
      tick();
      dmem_bus.dmem_ack      = 1'b0;
      vectors++; if (read_data !== 32'h11223344) begin miscompares++; $display("[TB] FAIL b2b0_read_data: got %h expected 11223344", read_data); end
      vectors++; if (dmem_bus.dmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b0_done_read: got %b expected 0", dmem_bus.dmem_read); end
      tick();
      address = 32'h4;
      #1;
      vectors++; if (busywait !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b1_issue_busy: got %b expected 1", busywait); end
      tick();
      vectors++; if (dmem_bus.dmem_address !== 30'h1) begin miscompares++; $display("[TB] FAIL b2b1_address: got %h expected 1", dmem_bus.dmem_address); end
      dmem_bus.dmem_readdata = 32'h55667788;
      dmem_bus.dmem_ack      = 1'b1;
      tick();
      dmem_bus.dmem_ack      = 1'b0;
      vectors++; if (read_data !== 32'h55667788) begin miscompares++; $display("[TB] FAIL b2b1_read_data: got %h expected 55667788", read_data); end
      clear_inputs();
      tick();
      tick();
      vectors++; if (read_req_cycles - start_count !== 2) begin miscompares++; $display("[TB] FAIL b2b_request_cycles: got %0d expected 2", read_req_cycles - start_count); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_store_word();
      test_store_byte_fwd();
      test_loads();
      test_misaligned();
      test_reset_in_access();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage data-memory access controller in the RV32IM pipeline; sits directly downstream of mem_fwd_unit.
- Consumes MEM_FWD_SEL to choose store data: the WB-stage load result or the MEM-stage register operand.
- Formats byte/half/word stores into lane-aligned write data and byte enables.
- Runs a request/acknowledge handshake with data memory, stalls the pipeline until the access completes, and returns sign- or zero-extended load data to the MEM/WB register.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the ALU.
- DATA_WIDTH, 32, data word width; fixed at 32, with 4 byte lanes.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- MEM_READ_EN  input  1  MEM-stage instruction is a load.
- MEM_WRITE_EN  input  1  MEM-stage instruction is a store.
- FUNC3  input  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ADDRESS  input  ADDR_WIDTH  byte address (ALU result).
- REG_DATA2  input  32  store operand from the MEM pipeline register.
- FWD_DATA_WB  input  32  WB-stage load data for store-data forwarding.
- MEM_FWD_SEL  input  1  1 selects FWD_DATA_WB as store data, 0 selects REG_DATA2.
- DMEM_READDATA  input  32  word read from memory; valid in the DMEM_ACK cycle.
- DMEM_ACK  input  1  one-cycle completion pulse from memory.
- DMEM_READ  output  1  read request.
- DMEM_WRITE  output  1  write request.
- DMEM_ADDRESS  output  ADDR_WIDTH-2  word address.
- DMEM_WRITEDATA  output  32  lane-replicated store data.
- DMEM_BYTE_EN  output  4  active byte lanes.
- READ_DATA  output  32  extended load result, registered.
- BUSYWAIT  output  1  pipeline stall request.
- MISALIGNED  output  1  misaligned access flag, combinational.

Behaviour:
- Clock and reset: one clock (CLK). RESET is synchronous and active-high.
- Reset values: state IDLE; DMEM_READ, DMEM_WRITE and BUSYWAIT = 0; DMEM_ADDRESS, DMEM_WRITEDATA, DMEM_BYTE_EN and READ_DATA = 0.
- States: IDLE, ACCESS, DONE.
- Access request: req = MEM_READ_EN | MEM_WRITE_EN. If both are asserted, the access is treated as a write.
- Misalignment:
  - MISALIGNED = req & ((word op & ADDRESS[1:0] != 0) | (half op & ADDRESS[0])).
  - It is asserted only in IDLE.
  - A misaligned access issues no memory request, sets BUSYWAIT = 0, and leaves READ_DATA unchanged.
- IDLE, aligned request:
  - BUSYWAIT = 1 combinationally in that same cycle.
  - At the clock edge, latch the word address (ADDRESS[ADDR_WIDTH-1:2]), byte offset, FUNC3 and formatted write data; go to ACCESS.
  - Store data is sampled only here: MEM_FWD_SEL ? FWD_DATA_WB : REG_DATA2.
- ACCESS:
  - DMEM_READ or DMEM_WRITE is held at 1, with address, data and byte enables stable, until DMEM_ACK.
  - BUSYWAIT = 1.
  - On DMEM_ACK, a load registers its extended result into READ_DATA; go to DONE.
- DONE:
  - Strobes drop to 0 and BUSYWAIT = 0, so the pipeline advances at the end of this cycle.
  - The same instruction is still presented in DONE and must not be re-issued; go to IDLE unconditionally.
- Latency: issue cycle, then at least one ACCESS cycle, then DONE. Minimum 3 cycles per access when DMEM_ACK arrives in the first ACCESS cycle.
- Store formatting (offset = ADDRESS[1:0]):
  - SB: byte replicated to all four lanes; BYTE_EN = 4'b0001 << offset.
  - SH: halfword replicated to both halves; BYTE_EN = 4'b0011 when offset = 0, 4'b1100 when offset = 2.
  - SW: BYTE_EN = 4'b1111.
  - Loads: DMEM_BYTE_EN = 4'b1111.
- Load extraction:
  - Select the lane(s) by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - An unlisted funct3 on a load behaves as LW.
- READ_DATA holds its value until the next load completes.
- DMEM_ACK outside ACCESS is ignored.
- RESET in ACCESS: the next edge forces IDLE, and the strobes deassert in the following cycle. A late DMEM_ACK arriving after that is ignored.

Decomposition:
- Shared package (hazard/pipeline package):
  - FUNC3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - 2-bit state encoding: IDLE = 0, ACCESS = 1, DONE = 2.
- One sub-module: load_align_unit. It is combinational and takes the word, offset and FUNC3, and returns the extended 32-bit value.
- Store formatting stays inline.

Test Plan:
- SW, ADDRESS = 0x0000_0010, REG_DATA2 = 0xDEADBEEF, MEM_FWD_SEL = 0, DMEM_ACK two cycles after issue -> DMEM_WRITE held 2 cycles; DMEM_ADDRESS = 0x4; BYTE_EN = 1111; WRITEDATA = 0xDEADBEEF; BUSYWAIT high 3 cycles, then low 1 cycle (DONE).
- SB, ADDRESS = 0x13, MEM_FWD_SEL = 1, FWD_DATA_WB = 0x000000A5, REG_DATA2 = 0x11111111 -> WRITEDATA = 0xA5A5A5A5; BYTE_EN = 1000.
- LB, ADDRESS = 0x22, DMEM_READDATA = 0x12F03456 -> READ_DATA = 0xFFFFFFF0. LBU at the same address -> 0x000000F0. LHU, ADDRESS = 0x22 -> 0x000012F0.
- LW, ADDRESS = 0x06 -> MISALIGNED = 1, no DMEM_READ, BUSYWAIT = 0, READ_DATA unchanged. SH, ADDRESS = 0x01 -> same response.
- RESET asserted while in ACCESS -> next edge in IDLE; strobes 0 the following cycle; READ_DATA = 0; a subsequent stray DMEM_ACK is ignored.
- Back-to-back loads LW at 0x0 then LW at 0x4 -> exactly one request per instruction; no re-issue in DONE; READ_DATA updates at each ACK.
